// File: rtl/dectape_pkg.sv
// rtl/dectape_pkg.sv - shared state encoding and default delays for the TU56 motion sequencer
//
// Purpose: state type and default millisecond delays used by dectape_motion_ctl.
// Ports:   none (package).

package dectape_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCEL = 3'd1,
    ST_RUN   = 3'd2,
    ST_TURN  = 3'd3,
    ST_RESEL = 3'd4,
    ST_COAST = 3'd5
  } motion_state_t;

  localparam int DEF_SPEED_MS = 120;
  localparam int DEF_TURN_MS  = 200;
  localparam int DEF_RESEL_MS = 1;
  localparam int DEF_CW       = 8;

endpackage

// File: rtl/dectape_ms_timer.sv
// rtl/dectape_ms_timer.sv - loadable millisecond down-counter with expiry pulse
//
// Purpose: counts ms_tick pulses down from a loaded value; expire is high on the
//          clk where a tick arrives while the counter holds 1.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-low reset
//   load     in   load n into the counter (wins over a coincident tick)
//   n        in   CW-bit delay value in milliseconds
//   ms_tick  in   one-clk pulse per millisecond
//   expire   out  combinational expiry pulse

module dectape_ms_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] n,
  input  logic          ms_tick,
  output logic          expire
);

  logic [CW-1:0] cnt;

  // A tick on the load clk is swallowed so the delay is exactly n ticks
  // counted from the clk after entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= n;
    end else if (ms_tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = ms_tick && (cnt == CW'(1));

endmodule

// File: rtl/dectape_motion_ctl.sv
// rtl/dectape_motion_ctl.sv - TU56 motion sequencer (go/direction/unit with start, turn, reselect and coast delays)
//
// Purpose: turns unit/direction/go commands into transport controls and enforces
//          start, turn-around, reselection and coast delays; gates the write strobe.
// Ports:
//   clk, reset (async active-low), ms_tick
//   cmd_valid/cmd_ready handshake with cmd_go, cmd_rev, cmd_unit[3:0]
//   all_halt   level, forces a stop
//   wr_req     write request from control
//   con_go, con_fwd, con_rev, con_select[3:0], con_wr   to tu56
//   up_to_speed (RUN only), busy (ACCEL/TURN/RESEL/COAST)

module dectape_motion_ctl
  import dectape_pkg::*;
#(
  parameter int SPEED_MS = DEF_SPEED_MS,
  parameter int TURN_MS  = DEF_TURN_MS,
  parameter int RESEL_MS = DEF_RESEL_MS,
  parameter int CW       = DEF_CW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ms_tick,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_go,
  input  logic       cmd_rev,
  input  logic [3:0] cmd_unit,
  input  logic       all_halt,
  input  logic       wr_req,
  output logic       con_go,
  output logic       con_fwd,
  output logic       con_rev,
  output logic [3:0] con_select,
  output logic       con_wr,
  output logic       up_to_speed,
  output logic       busy
);

  localparam logic [CW-1:0] SPEED_N = CW'(SPEED_MS);
  localparam logic [CW-1:0] TURN_N  = CW'(TURN_MS);
  localparam logic [CW-1:0] RESEL_N = CW'(RESEL_MS);

  motion_state_t state_q, state_d;
  logic [3:0]    sel_d;
  logic          rev_d;
  logic          load;
  logic [CW-1:0] load_n;
  logic          expire;
  logic          accept;

  dectape_ms_timer #(.CW(CW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .n       (load_n),
    .ms_tick (ms_tick),
    .expire  (expire)
  );

  // Ready is decoded from the state register but masked by the halt level so
  // that no command can slip in on the first halted clk.
  assign cmd_ready = ((state_q == ST_IDLE) || (state_q == ST_RUN)) && !all_halt;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = con_select;
    rev_d   = con_rev;
    load    = 1'b0;
    load_n  = '0;
    if (all_halt) begin
      unique case (state_q)
        ST_ACCEL, ST_RUN, ST_TURN, ST_RESEL: begin
          state_d = ST_COAST;
          load    = 1'b1;
          load_n  = SPEED_N;
        end
        ST_COAST: if (expire) state_d = ST_IDLE;
        default: ;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept && cmd_go) begin
            sel_d   = cmd_unit;
            rev_d   = cmd_rev;
            state_d = ST_ACCEL;
            load    = 1'b1;
            load_n  = SPEED_N;
          end
        end
        ST_ACCEL: if (expire) state_d = ST_RUN;
        ST_RUN: begin
          if (accept) begin
            if (!cmd_go) begin
              state_d = ST_COAST;
              load    = 1'b1;
              load_n  = SPEED_N;
            end else if (cmd_unit != con_select) begin
              // A new unit must come up to speed from scratch, so any
              // direction change rides along with the reselection.
              sel_d   = cmd_unit;
              rev_d   = cmd_rev;
              state_d = ST_RESEL;
              load    = 1'b1;
              load_n  = RESEL_N;
            end else if (cmd_rev != con_rev) begin
              rev_d   = cmd_rev;
              state_d = ST_TURN;
              load    = 1'b1;
              load_n  = TURN_N;
            end
          end
        end
        ST_TURN: if (expire) state_d = ST_RUN;
        ST_RESEL: begin
          if (expire) begin
            state_d = ST_ACCEL;
            load    = 1'b1;
            load_n  = SPEED_N;
          end
        end
        ST_COAST: if (expire) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      con_select  <= 4'd0;
      con_rev     <= 1'b0;
      con_fwd     <= 1'b1;
      con_go      <= 1'b0;
      up_to_speed <= 1'b0;
      busy        <= 1'b0;
      con_wr      <= 1'b0;
    end else begin
      state_q     <= state_d;
      con_select  <= sel_d;
      con_rev     <= rev_d;
      con_fwd     <= !rev_d;
      con_go      <= (state_d == ST_ACCEL) || (state_d == ST_RUN) ||
                     (state_d == ST_TURN)  || (state_d == ST_RESEL);
      up_to_speed <= (state_d == ST_RUN);
      busy        <= (state_d == ST_ACCEL) || (state_d == ST_TURN) ||
                     (state_d == ST_RESEL) || (state_d == ST_COAST);
      // Uses the registered up_to_speed, so the strobe trails it by one clk
      // except under halt, which kills it immediately.
      con_wr      <= wr_req && up_to_speed && !all_halt;
    end
  end

endmodule

// File: tb/tb_dectape_motion_ctl.sv
// tb/tb_dectape_motion_ctl.sv - directed self-checking bench for dectape_motion_ctl

module tb_dectape_motion_ctl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ms_tick = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_go = 1'b0;
  logic       cmd_rev = 1'b0;
  logic [3:0] cmd_unit = 4'd0;
  logic       all_halt = 1'b0;
  logic       wr_req = 1'b0;
  logic       con_go, con_fwd, con_rev, con_wr, up_to_speed, busy;
  logic [3:0] con_select;

  int checks = 0;
  int failures = 0;

  dectape_motion_ctl #(
    .SPEED_MS(4), .TURN_MS(200), .RESEL_MS(1), .CW(8)
  ) dut (
    .clk(clk), .reset(reset), .ms_tick(ms_tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_go(cmd_go),
    .cmd_rev(cmd_rev), .cmd_unit(cmd_unit), .all_halt(all_halt),
    .wr_req(wr_req), .con_go(con_go), .con_fwd(con_fwd), .con_rev(con_rev),
    .con_select(con_select), .con_wr(con_wr), .up_to_speed(up_to_speed),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    ms_tick = 1'b1;
    step();
    ms_tick = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_go"},     {31'd0, con_go},      32'd0);
    check({tag, "_fwd"},    {31'd0, con_fwd},     32'd1);
    check({tag, "_rev"},    {31'd0, con_rev},     32'd0);
    check({tag, "_sel"},    {28'd0, con_select},  32'd0);
    check({tag, "_wr"},     {31'd0, con_wr},      32'd0);
    check({tag, "_uts"},    {31'd0, up_to_speed}, 32'd0);
    check({tag, "_busy"},   {31'd0, busy},        32'd0);
    check({tag, "_ready"},  {31'd0, cmd_ready},   32'd1);
  endtask

  initial begin
    // 1: reset, then go unit 3 forward
    #12;
    check_reset_vals("rst");
    reset = 1'b1;
    step();
    cmd_valid = 1'b1; cmd_go = 1'b1; cmd_rev = 1'b0; cmd_unit = 4'd3;
    step();
    cmd_valid = 1'b0;
    check("t1_go",    {31'd0, con_go},     32'd1);
    check("t1_sel",   {28'd0, con_select}, 32'd3);
    check("t1_busy",  {31'd0, busy},       32'd1);
    check("t1_ready", {31'd0, cmd_ready},  32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("t1_uts_3", {31'd0, up_to_speed}, 32'd0);
    tick();
    check("t1_uts_4",  {31'd0, up_to_speed}, 32'd1);
    check("t1_busy_4", {31'd0, busy},        32'd0);

    // 2: same unit, reverse -> TURN for 200 ticks
    cmd_valid = 1'b1; cmd_go = 1'b1; cmd_rev = 1'b1; cmd_unit = 4'd3;
    step();
    cmd_valid = 1'b0;
    check("t2_rev",  {31'd0, con_rev},     32'd1);
    check("t2_fwd",  {31'd0, con_fwd},     32'd0);
    check("t2_busy", {31'd0, busy},        32'd1);
    check("t2_uts",  {31'd0, up_to_speed}, 32'd0);
    for (int i = 0; i < 199; i++) tick();
    check("t2_uts_199", {31'd0, up_to_speed}, 32'd0);
    check("t2_go_199",  {31'd0, con_go},      32'd1);
    tick();
    check("t2_uts_200", {31'd0, up_to_speed}, 32'd1);

    // 3: unit change 3 -> 5, RESEL 1 tick then ACCEL 4 ticks
    cmd_valid = 1'b1; cmd_go = 1'b1; cmd_rev = 1'b1; cmd_unit = 4'd5;
    step();
    cmd_valid = 1'b0;
    check("t3_sel",  {28'd0, con_select},  32'd5);
    check("t3_uts",  {31'd0, up_to_speed}, 32'd0);
    check("t3_busy", {31'd0, busy},        32'd1);
    tick();
    check("t3_resel_done_busy", {31'd0, busy},        32'd1);
    check("t3_resel_done_uts",  {31'd0, up_to_speed}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("t3_uts_3", {31'd0, up_to_speed}, 32'd0);
    tick();
    check("t3_uts_4", {31'd0, up_to_speed}, 32'd1);

    // 4: write gating and all_halt
    wr_req = 1'b1;
    step();
    check("t4_wr_on", {31'd0, con_wr}, 32'd1);
    all_halt = 1'b1;
    #1;
    check("t4_ready_halt_comb", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b1; cmd_go = 1'b1; cmd_unit = 4'd2;
    step();
    check("t4_go",   {31'd0, con_go},      32'd0);
    check("t4_wr",   {31'd0, con_wr},      32'd0);
    check("t4_uts",  {31'd0, up_to_speed}, 32'd0);
    check("t4_busy", {31'd0, busy},        32'd1);
    for (int i = 0; i < 3; i++) tick();
    check("t4_busy_3", {31'd0, busy}, 32'd1);
    tick();
    check("t4_busy_4",  {31'd0, busy},       32'd0);
    check("t4_ready_h", {31'd0, cmd_ready},  32'd0);
    step();
    check("t4_go_ign",  {31'd0, con_go},     32'd0);
    check("t4_sel_ign", {28'd0, con_select}, 32'd5);
    cmd_valid = 1'b0; all_halt = 1'b0; wr_req = 1'b0;
    #1;
    check("t4_ready_rel", {31'd0, cmd_ready}, 32'd1);

    // 5: command held during ACCEL is accepted on the first RUN clk
    step();
    cmd_valid = 1'b1; cmd_go = 1'b1; cmd_rev = 1'b0; cmd_unit = 4'd2;
    step();
    check("t5_sel", {28'd0, con_select}, 32'd2);
    cmd_rev = 1'b1;
    #1;
    check("t5_ready_accel", {31'd0, cmd_ready}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("t5_ready_3", {31'd0, cmd_ready}, 32'd0);
    check("t5_rev_3",   {31'd0, con_rev},   32'd0);
    tick();
    check("t5_ready_run", {31'd0, cmd_ready}, 32'd1);
    check("t5_rev_run",   {31'd0, con_rev},   32'd0);
    step();
    cmd_valid = 1'b0;
    check("t5_rev_turn",  {31'd0, con_rev}, 32'd1);
    check("t5_busy_turn", {31'd0, busy},    32'd1);

    // 6: asynchronous reset during TURN
    for (int i = 0; i < 5; i++) tick();
    check("t6_pre_go", {31'd0, con_go}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("t6");
    step();
    reset = 1'b1;
    step();
    check_reset_vals("t6_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
